sync_zm_to_u2_conv: RTL and testbench
=====================================

Name: sync_zm_to_u2_conv

Overview:
- Pipelined converter from sign-magnitude (ZM) to two's complement (U2).
- It is the inverse of the ALU_CONV operation in the 4-bit ALU, and sits on the ALU operand path so that ZM-encoded values can be turned back into U2 before arithmetic.
- Streaming valid/ready interface on both sides, with backpressure.
- Provides per-word status flags and a transfer counter.

Parameters:
- M, 4, data word width in bits (>= 2); MSB is the ZM sign bit.
- CNT_W, 8, width of the output-transfer counter.

Ports:
- i_clk  input  1  system clock, rising edge.
- i_reset  input  1  asynchronous, active-low reset.
- i_valid  input  1  upstream word valid.
- o_ready  output  1  converter can accept a word this cycle.
- i_arg_A  input  M  ZM input word: bit M-1 is the sign, bits M-2..0 are the magnitude.
- o_valid  output  1  output word valid.
- i_ready  input  1  downstream accepts the output word.
- o_result  output  M  U2 result word.
- o_status  output  4  flags qualified by o_valid:
  - [0] result is zero
  - [1] result is negative
  - [2] input was negative zero
  - [3] sticky negative-zero seen
- i_clr  input  1  synchronous clear of o_count and o_status[3].
- o_count  output  CNT_W  number of completed output transfers, wraps modulo 2^CNT_W.

Behaviour:
- Reset (i_reset=0, asynchronous):
  - s1_valid=0, s2_valid=0.
  - o_valid=0, o_result=0, o_status=0, o_count=0, sticky=0.
  - o_ready=1 after reset.
- Transfers: an input transfer occurs when i_valid&&o_ready; an output transfer occurs when o_valid&&i_ready.
- Two register stages:
  - S1 latches the sign and the magnitude.
  - S2 holds the converted result and its flags.
- Advance rules:
  - adv2 = !s2_valid || i_ready
  - adv1 = !s1_valid || adv2
  - o_ready = adv1. This is combinational from i_ready; it is the only combinational in-to-out path.
- Latency: 2 cycles from input transfer to o_valid with no backpressure. Throughput is 1 word/cycle.
- Backpressure: while o_valid=1 and i_ready=0, o_result and o_status hold stable. Once both stages are full, o_ready=0. No word is dropped or duplicated.
- Conversion in S2:
  - sign=0: result = {1'b0, mag}.
  - sign=1: result = (~{1'b0, mag} + 1) mod 2^M.
  - Negative zero (sign=1, mag=0) yields 0.
  - The ZM range always fits in U2, so no overflow is possible.
- Flags, computed in S2:
  - [0] = (result==0).
  - [1] = result[M-1].
  - [2] = sign && (mag==0).
  - [3] = sticky, set on any S2 load with the negative-zero condition.
- o_count increments by 1 on each output transfer.
- i_clr:
  - Zeroes o_count and the sticky bit next edge.
  - If a transfer occurs in the same cycle, clear wins: count=0.
  - If negative zero loads in the same cycle, set wins: sticky=1.
  - i_clr does not flush the pipeline.
- Simultaneous in/out when both stages are full and i_ready=1: S2 takes S1, S1 takes the input word, and o_ready=1 that cycle.
- Reset mid-stream: in-flight words are discarded and all state returns to reset values immediately.
- Reset deassertion is assumed to be synchronized externally.

Optional Feature:
- ZM_NEGZERO_FLAG_EN.
- Defined: o_status[2] and o_status[3] behave as above.
- Undefined:
  - o_status[3:2] are tied to 0, and the sticky register and its i_clr path are removed.
  - Negative zero still converts to 0.
  - o_status[1:0] and o_count are unaffected.

Test Plan:
- Reset with i_valid=1 held → o_valid=0, o_count=0, o_status=0000. After i_reset=1, o_ready=1.
- M=4, stream 0101, 1011, 1111, 0000 with i_ready=1 → outputs 0101, 1101, 1001, 0000 on cycles +2..+5. Status [1:0] are 00, 10, 10, 01. o_count=4.
- Input 1000 → o_result=0000 and o_status=1101 (with ZM_NEGZERO_FLAG_EN defined). Next word 0011 → status 1000. Pulse i_clr → status[3]=0 and o_count=0.
- Stream 4 words with i_ready=0 for 3 cycles → o_ready drops to 0 after 2 words accepted. o_result stays 1101 stable. On release, all words emerge in order with none lost.
- Assert i_reset=0 with both stages full → o_valid=0 immediately, and the old words never appear after release.
- Drive CNT_W=2 with 5 output transfers → o_count sequence 1,2,3,0,1.

Source files
------------

// File: rtl/sync_zm_to_u2_conv.sv
// Two-stage valid/ready converter from sign-magnitude to two's complement, with status flags
// and an output-transfer counter. The optional negative-zero flags are enabled by ZM_NEGZERO_FLAG_EN.
module sync_zm_to_u2_conv #(
  parameter int unsigned M     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_valid,
  output logic             o_ready,
  input  logic [M-1:0]     i_arg_A,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [M-1:0]     o_result,
  output logic [3:0]       o_status,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_count
);

  logic             s1_valid_q;
  logic             s1_sign_q;
  logic [M-2:0]     s1_mag_q;
  logic             s2_valid_q;
  logic [M-1:0]     s2_result_q;
  logic             s2_zero_q;
  logic             s2_neg_q;
  logic [CNT_W-1:0] count_q;

  logic             adv1, adv2, s2_load, out_xfer;
  logic [M-1:0]     mag_ext, result_d;
  logic             negzero_d;

  // Stage 2 advances when it is empty or draining. Stage 1 advances when stage 2 has room.
  assign adv2     = !s2_valid_q || i_ready;
  assign adv1     = !s1_valid_q || adv2;
  assign s2_load  = adv2 && s1_valid_q;
  assign out_xfer = s2_valid_q && i_ready;

  always_comb begin
    mag_ext   = {1'b0, s1_mag_q};
    result_d  = s1_sign_q ? (~mag_ext + M'(1)) : mag_ext;
    negzero_d = s1_sign_q && (s1_mag_q == '0);
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      s1_valid_q <= 1'b0;
      s1_sign_q  <= 1'b0;
      s1_mag_q   <= '0;
    end else if (adv1) begin
      s1_valid_q <= i_valid;
      if (i_valid) begin
        s1_sign_q <= i_arg_A[M-1];
        s1_mag_q  <= i_arg_A[M-2:0];
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      s2_valid_q  <= 1'b0;
      s2_result_q <= '0;
      s2_zero_q   <= 1'b0;
      s2_neg_q    <= 1'b0;
    end else if (adv2) begin
      s2_valid_q <= s1_valid_q;
      if (s1_valid_q) begin
        s2_result_q <= result_d;
        s2_zero_q   <= (result_d == '0);
        s2_neg_q    <= result_d[M-1];
      end
    end
  end

  // A clear in the same cycle as a transfer leaves the counter at zero.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset)      count_q <= '0;
    else if (i_clr)    count_q <= '0;
    else if (out_xfer) count_q <= count_q + CNT_W'(1);
  end

`ifdef ZM_NEGZERO_FLAG_EN
  logic s2_negzero_q;
  logic sticky_q;

  // A negative-zero load in the same cycle as a clear leaves the sticky bit set.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      s2_negzero_q <= 1'b0;
      sticky_q     <= 1'b0;
    end else begin
      if (s2_load) s2_negzero_q <= negzero_d;
      if (s2_load && negzero_d) sticky_q <= 1'b1;
      else if (i_clr)           sticky_q <= 1'b0;
    end
  end

  assign o_status = {sticky_q, s2_negzero_q, s2_neg_q, s2_zero_q};
`else
  logic unused_negzero;
  assign unused_negzero = s2_load & negzero_d;
  assign o_status = {2'b00, s2_neg_q, s2_zero_q};
`endif

  assign o_ready  = adv1;
  assign o_valid  = s2_valid_q;
  assign o_result = s2_result_q;
  assign o_count  = count_q;

endmodule

// File: tb/tb_sync_zm_to_u2_conv.sv
// Directed bench for sync_zm_to_u2_conv: a ZM->U2 vector table plus hand-built sequences
// for negative-zero flags, clear priority, backpressure, mid-stream reset and counter wrap.
module tb_sync_zm_to_u2_conv;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       i_valid, i_ready, i_clr;
  logic [3:0] i_arg_A;
  logic       o_ready, o_valid, o_ready2, o_valid2;
  logic [3:0] o_result, o_status, o_result2, o_status2;
  logic [7:0] o_count;
  logic [1:0] o_count2;

  always #5 clk = ~clk;

  sync_zm_to_u2_conv #(.M(4), .CNT_W(8)) dut (
    .i_clk(clk), .i_reset(rst_n), .i_valid(i_valid), .o_ready(o_ready),
    .i_arg_A(i_arg_A), .o_valid(o_valid), .i_ready(i_ready), .o_result(o_result),
    .o_status(o_status), .i_clr(i_clr), .o_count(o_count)
  );

  sync_zm_to_u2_conv #(.M(4), .CNT_W(2)) dut2 (
    .i_clk(clk), .i_reset(rst_n), .i_valid(i_valid), .o_ready(o_ready2),
    .i_arg_A(i_arg_A), .o_valid(o_valid2), .i_ready(i_ready), .o_result(o_result2),
    .o_status(o_status2), .i_clr(i_clr), .o_count(o_count2)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] res;
    logic [2:0] st;   // {negzero, negative, zero}
  } vec_t;

  vec_t vec[20];
  int   n_total  = 0;
  int   n_passed = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_passed++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [3:0] st_exp(input logic sticky, input logic [2:0] s);
`ifdef ZM_NEGZERO_FLAG_EN
    return {sticky, s};
`else
    return {2'b00, s[1:0]};
`endif
  endfunction

  task automatic cycle();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    i_valid = 1'b0; i_clr = 1'b0; i_ready = 1'b1; i_arg_A = '0;
    rst_n = 1'b0;
    cycle(); cycle();
    rst_n = 1'b1;
  endtask

  // Streams vec[base+pre .. base+n-1] and checks outputs vec[base .. base+n-1] in order.
  task automatic run_stream(input int base, input int n, input int pre, input bit chk_lat);
    int in_idx, out_idx, cyc;
    logic xfer;
    logic [3:0] se;
    in_idx = pre; out_idx = 0; cyc = 0;
    i_ready = 1'b1;
    while (out_idx < n && cyc < 200) begin
      i_valid = (in_idx < n);
      i_arg_A = (in_idx < n) ? vec[base+in_idx].a : 4'h0;
      @(negedge clk);
      if (o_valid) begin
        se = st_exp(1'b0, vec[base+out_idx].st);
        check("stream_result", {28'h0, o_result}, {28'h0, vec[base+out_idx].res});
        check("stream_status", {29'h0, o_status[2:0]}, {29'h0, se[2:0]});
        if (chk_lat) check("stream_latency", cyc, out_idx + 2);
        out_idx++;
      end
      xfer = i_valid && o_ready;
      cycle();
      if (xfer) in_idx++;
      cyc++;
    end
    i_valid = 1'b0;
    if (out_idx < n) check("stream_timeout", out_idx, n);
  endtask

  initial begin
    logic seen;
    int   in_idx;
    logic xfer;
    logic [3:0] cnt2_exp[5];

    vec[0]  = '{4'b0101, 4'b0101, 3'b000};
    vec[1]  = '{4'b1011, 4'b1101, 3'b010};
    vec[2]  = '{4'b1111, 4'b1001, 3'b010};
    vec[3]  = '{4'b0000, 4'b0000, 3'b001};
    vec[4]  = '{4'b0001, 4'b0001, 3'b000};
    vec[5]  = '{4'b0010, 4'b0010, 3'b000};
    vec[6]  = '{4'b0011, 4'b0011, 3'b000};
    vec[7]  = '{4'b0100, 4'b0100, 3'b000};
    vec[8]  = '{4'b0110, 4'b0110, 3'b000};
    vec[9]  = '{4'b0111, 4'b0111, 3'b000};
    vec[10] = '{4'b1000, 4'b0000, 3'b101};
    vec[11] = '{4'b1001, 4'b1111, 3'b010};
    vec[12] = '{4'b1010, 4'b1110, 3'b010};
    vec[13] = '{4'b1100, 4'b1100, 3'b010};
    vec[14] = '{4'b1101, 4'b1011, 3'b010};
    vec[15] = '{4'b1110, 4'b1010, 3'b010};
    vec[16] = '{4'b1011, 4'b1101, 3'b010};
    vec[17] = '{4'b0101, 4'b0101, 3'b000};
    vec[18] = '{4'b1111, 4'b1001, 3'b010};
    vec[19] = '{4'b0001, 4'b0001, 3'b000};
    cnt2_exp = '{4'd1, 4'd2, 4'd3, 4'd0, 4'd1};

    // Reset held with a valid input present
    rst_n = 1'b0; i_valid = 1'b1; i_ready = 1'b1; i_clr = 1'b0; i_arg_A = 4'b0101;
    cycle(); cycle(); cycle();
    check("rst_valid", {31'h0, o_valid}, 32'h0);
    check("rst_count", {24'h0, o_count}, 32'h0);
    check("rst_status", {28'h0, o_status}, 32'h0);
    check("rst_result", {28'h0, o_result}, 32'h0);
    i_valid = 1'b0; rst_n = 1'b1; #1;
    check("rst_ready", {31'h0, o_ready}, 32'h1);

    // Full table, back to back, no backpressure
    run_stream(0, 16, 0, 1'b1);
    check("table_count", {24'h0, o_count}, 32'd16);

    // Negative zero, sticky flag and clear
    do_reset();
    i_valid = 1'b1; i_arg_A = 4'b1000; cycle();
    i_valid = 1'b0; cycle();
    check("nz_valid", {31'h0, o_valid}, 32'h1);
    check("nz_result", {28'h0, o_result}, 32'h0);
    check("nz_status", {28'h0, o_status}, {28'h0, st_exp(1'b1, 3'b101)});
    i_valid = 1'b1; i_arg_A = 4'b0011; cycle();
    i_valid = 1'b0; cycle();
    check("after_nz_result", {28'h0, o_result}, 32'h3);
    check("after_nz_status", {28'h0, o_status}, {28'h0, st_exp(1'b1, 3'b000)});
    check("after_nz_count", {24'h0, o_count}, 32'd1);
    cycle();
    check("count_two", {24'h0, o_count}, 32'd2);
    i_clr = 1'b1; cycle(); i_clr = 1'b0;
    check("clr_count", {24'h0, o_count}, 32'd0);
    check("clr_status", {28'h0, o_status}, 32'h0);

    // Clear coinciding with a negative-zero load, then with an output transfer
    i_valid = 1'b1; i_arg_A = 4'b1000; cycle();
    i_valid = 1'b0; i_clr = 1'b1; cycle();
    check("clr_vs_set_status", {28'h0, o_status}, {28'h0, st_exp(1'b1, 3'b101)});
    cycle();
    check("clr_vs_xfer_count", {24'h0, o_count}, 32'd0);
    i_clr = 1'b0;

    // Backpressure: two words fill the pipe, then the output holds
    i_ready = 1'b0; in_idx = 0;
    for (int c = 0; c < 5; c++) begin
      i_valid = 1'b1; i_arg_A = vec[16+in_idx].a;
      @(negedge clk);
      xfer = o_ready;
      if (c == 2 || c == 4) begin
        check("bp_ready", {31'h0, o_ready}, 32'h0);
        check("bp_valid", {31'h0, o_valid}, 32'h1);
        check("bp_result", {28'h0, o_result}, 32'hD);
      end
      cycle();
      if (xfer) in_idx++;
    end
    check("bp_accepted", in_idx, 2);
    run_stream(16, 4, in_idx, 1'b0);

    // Reset with both stages full
    i_ready = 1'b0;
    i_valid = 1'b1; i_arg_A = 4'b0111; cycle();
    i_arg_A = 4'b0110; cycle();
    i_valid = 1'b0; #1;
    check("full_valid", {31'h0, o_valid}, 32'h1);
    check("full_ready", {31'h0, o_ready}, 32'h0);
    rst_n = 1'b0; #1;
    check("midrst_valid", {31'h0, o_valid}, 32'h0);
    check("midrst_result", {28'h0, o_result}, 32'h0);
    check("midrst_count", {24'h0, o_count}, 32'h0);
    #2; rst_n = 1'b1; i_ready = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      if (o_valid) seen = 1'b1;
    end
    check("midrst_no_ghost", {31'h0, seen}, 32'h0);
    cycle();

    // Narrow counter wraps modulo 4
    for (int k = 0; k < 5; k++) begin
      i_valid = 1'b1; i_arg_A = 4'b0001; cycle();
      i_valid = 1'b0; cycle();
      cycle();
      check("cnt2_wrap", {30'h0, o_count2}, {28'h0, cnt2_exp[k]});
    end
    check("cnt8_after_wrap", {24'h0, o_count}, 32'd5);

    $display("%0d/%0d checks passed", n_passed, n_total);
    $finish;
  end

endmodule
